// File: rtl/decode_pipe.sv
// RV32 decode stage: one instruction per cycle into ALU/memory control, immediate
// and operand values, with an internal register file, writeback bypass and load-use stall.
module decode_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int FORWARD  = 1
) (
  input  logic            req,
  input  logic            rst_n,
  input  logic            flush_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      wb_rd_in,
  input  logic            wb_write_in,
  input  logic [XLEN-1:0] wb_value_in,
  input  logic [4:0]      ex_rd_in,
  input  logic            ex_load_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [6:0]      alu_op_out,
  output logic            alu_sub_sra_out,
  output logic [1:0]      alu_src1_out,
  output logic [1:0]      alu_src2_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            illegal_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [15:0]     stall_count_out
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {SRC1_RS1 = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2} src1_e;
  typedef enum logic [1:0] {SRC2_RS2 = 2'd0, SRC2_IMM = 2'd1} src2_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_write;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      alu_op;
    logic            sub_sra;
    src1_e           src1;
    src2_e           src2;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } bundle_t;

  logic [XLEN-1:0] regs [NUM_REGS];
  bundle_t         dec;
  bundle_t         q;
  logic            valid_q;
  logic [15:0]     stall_q;

  logic [6:0] opcode;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic       known, rs1_read, rs2_read, writes_rd;
  logic       hazard, accept;

  assign opcode = instr_in[6:0];
  assign rs1_f  = instr_in[19:15];
  assign rs2_f  = instr_in[24:20];
  assign rd_f   = instr_in[11:7];

  function automatic logic fits(input logic [4:0] idx);
    return {1'b0, idx} < NUM_REGS_W;
  endfunction

  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    if (idx == 5'd0 || !fits(idx))
      return '0;
    else if (FORWARD != 0 && wb_write_in && wb_rd_in == idx)
      return wb_value_in;
    else
      return regs[idx[IDX_W-1:0]];
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    known     = 1'b1;
    rs1_read  = 1'b1;
    rs2_read  = 1'b0;
    writes_rd = 1'b1;
    dec       = '0;
    dec.src1  = SRC1_RS1;
    dec.src2  = SRC2_IMM;
    unique case (opcode)
      OP_R: begin
        dec.src2    = SRC2_RS2;
        rs2_read    = 1'b1;
        dec.sub_sra = instr_in[30];
      end
      OP_IMM: begin
        dec.imm     = {{(XLEN-11){instr_in[31]}}, instr_in[30:20]};
        dec.sub_sra = (instr_in[14:12] == 3'b101) & instr_in[30];
      end
      OP_LOAD: begin
        dec.imm      = {{(XLEN-11){instr_in[31]}}, instr_in[30:20]};
        dec.mem_read = 1'b1;
      end
      OP_STORE: begin
        dec.imm       = {{(XLEN-11){instr_in[31]}}, instr_in[30:25], instr_in[11:7]};
        dec.mem_write = 1'b1;
        rs2_read      = 1'b1;
        writes_rd     = 1'b0;
      end
      OP_BRANCH: begin
        dec.imm   = {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
        dec.src2  = SRC2_RS2;
        rs2_read  = 1'b1;
        writes_rd = 1'b0;
      end
      OP_LUI: begin
        dec.imm  = {{(XLEN-31){instr_in[31]}}, instr_in[30:12], 12'b0};
        dec.src1 = SRC1_ZERO;
        rs1_read = 1'b0;
      end
      OP_AUIPC: begin
        dec.imm  = {{(XLEN-31){instr_in[31]}}, instr_in[30:12], 12'b0};
        dec.src1 = SRC1_PC;
        rs1_read = 1'b0;
      end
      OP_JAL: begin
        dec.imm  = {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
        dec.src1 = SRC1_PC;
        rs1_read = 1'b0;
      end
      OP_JALR: begin
        dec.imm = {{(XLEN-11){instr_in[31]}}, instr_in[30:20]};
      end
      default: begin
        // Unknown opcodes read nothing and carry no operand routing.
        known     = 1'b0;
        rs1_read  = 1'b0;
        writes_rd = 1'b0;
        dec.src2  = SRC2_RS2;
      end
    endcase

    dec.illegal = !known
                | (rs1_read  & !fits(rs1_f))
                | (rs2_read  & !fits(rs2_f))
                | (writes_rd & !fits(rd_f));

    dec.pc        = pc_in;
    dec.rs1       = rs1_read ? rs1_f : 5'd0;
    dec.rs2       = rs2_read ? rs2_f : 5'd0;
    dec.rd        = rd_f;
    dec.rd_write  = writes_rd & !dec.illegal;
    dec.mem_read  = dec.mem_read & !dec.illegal;
    dec.mem_write = dec.mem_write & !dec.illegal;
    dec.funct3    = instr_in[14:12];
    dec.funct7    = instr_in[31:25];
    dec.alu_op    = opcode;
    dec.rs1_value = rs1_read ? read_reg(rs1_f) : '0;
    dec.rs2_value = rs2_read ? read_reg(rs2_f) : '0;
  end

  assign hazard = in_valid & ex_load_in & (ex_rd_in != 5'd0)
                & ((rs1_read & (rs1_f == ex_rd_in)) | (rs2_read & (rs2_f == ex_rd_in)));

  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign in_ready = rst_n & (!valid_q | out_ready) & !hazard & !flush_in;
  assign accept   = in_valid & in_ready;

  // NOTE: the register file is reset explicitly because it must read back as zero after reset;
  // this forces flops rather than a RAM macro.
  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_write_in && wb_rd_in != 5'd0 && fits(wb_rd_in)) begin
      regs[wb_rd_in[IDX_W-1:0]] <= wb_value_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= dec;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (hazard && !flush_in && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign out_valid       = valid_q;
  assign pc_out          = q.pc;
  assign rs1_out         = q.rs1;
  assign rs2_out         = q.rs2;
  assign rd_out          = q.rd;
  assign rd_write_out    = q.rd_write;
  assign funct3_out      = q.funct3;
  assign funct7_out      = q.funct7;
  assign alu_op_out      = q.alu_op;
  assign alu_sub_sra_out = q.sub_sra;
  assign alu_src1_out    = q.src1;
  assign alu_src2_out    = q.src2;
  assign mem_read_out    = q.mem_read;
  assign mem_write_out   = q.mem_write;
  assign illegal_out     = q.illegal;
  assign imm_value_out   = q.imm;
  assign rs1_value_out   = q.rs1_value;
  assign rs2_value_out   = q.rs2_value;
  assign stall_count_out = stall_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: a default instance (bypass on, 32 regs) and a
// second instance (bypass off, 16 regs) driven with identical stimulus.
module tb_decode_pipe;

  logic        req = 1'b0;
  logic        rst_n, flush_in, in_valid, out_ready, wb_write_in, ex_load_in;
  logic [31:0] instr_in, pc_in, wb_value_in;
  logic [4:0]  wb_rd_in, ex_rd_in;

  logic        a_in_ready, a_out_valid, a_rd_write, a_sub, a_mread, a_mwrite, a_illegal;
  logic [31:0] a_pc, a_imm, a_rs1_val, a_rs2_val;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7, a_op;
  logic [1:0]  a_src1, a_src2;
  logic [15:0] a_stall;

  logic        b_in_ready, b_out_valid, b_rd_write, b_sub, b_mread, b_mwrite, b_illegal;
  logic [31:0] b_pc, b_imm, b_rs1_val, b_rs2_val;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7, b_op;
  logic [1:0]  b_src1, b_src2;
  logic [15:0] b_stall;

  int checks = 0;
  int errors = 0;

  always #5 req = ~req;

  decode_pipe #(.XLEN(32), .NUM_REGS(32), .FORWARD(1)) dut_a (
    .req(req), .rst_n(rst_n), .flush_in(flush_in), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .wb_rd_in(wb_rd_in), .wb_write_in(wb_write_in),
    .wb_value_in(wb_value_in), .ex_rd_in(ex_rd_in), .ex_load_in(ex_load_in),
    .out_valid(a_out_valid), .out_ready(out_ready), .pc_out(a_pc), .rs1_out(a_rs1),
    .rs2_out(a_rs2), .rd_out(a_rd), .rd_write_out(a_rd_write), .funct3_out(a_f3),
    .funct7_out(a_f7), .alu_op_out(a_op), .alu_sub_sra_out(a_sub), .alu_src1_out(a_src1),
    .alu_src2_out(a_src2), .mem_read_out(a_mread), .mem_write_out(a_mwrite),
    .illegal_out(a_illegal), .imm_value_out(a_imm), .rs1_value_out(a_rs1_val),
    .rs2_value_out(a_rs2_val), .stall_count_out(a_stall)
  );

  decode_pipe #(.XLEN(32), .NUM_REGS(16), .FORWARD(0)) dut_b (
    .req(req), .rst_n(rst_n), .flush_in(flush_in), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .wb_rd_in(wb_rd_in), .wb_write_in(wb_write_in),
    .wb_value_in(wb_value_in), .ex_rd_in(ex_rd_in), .ex_load_in(ex_load_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .pc_out(b_pc), .rs1_out(b_rs1),
    .rs2_out(b_rs2), .rd_out(b_rd), .rd_write_out(b_rd_write), .funct3_out(b_f3),
    .funct7_out(b_f7), .alu_op_out(b_op), .alu_sub_sra_out(b_sub), .alu_src1_out(b_src1),
    .alu_src2_out(b_src2), .mem_read_out(b_mread), .mem_write_out(b_mwrite),
    .illegal_out(b_illegal), .imm_value_out(b_imm), .rs1_value_out(b_rs1_val),
    .rs2_value_out(b_rs2_val), .stall_count_out(b_stall)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2;
    logic        rd_write;
    logic [1:0]  src1, src2;
    logic        sub, mread, mwrite, illegal;
    logic [31:0] imm, rs1_val, rs2_val;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge req);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    instr_in = instr;
    pc_in    = pc;
  endtask

  initial begin
    // Register state seen by the table: x5=0x10, x6=3, others 0.
    vecs[0]  = '{32'h123450B7, 5'd0, 5'd0, 1, 2'd2, 2'd1, 0, 0, 0, 0, 32'h12345000, 32'h0,  32'h0};  // lui
    vecs[1]  = '{32'hFFFFF117, 5'd0, 5'd0, 1, 2'd1, 2'd1, 0, 0, 0, 0, 32'hFFFFF000, 32'h0,  32'h0};  // auipc
    vecs[2]  = '{32'hFFDFF0EF, 5'd0, 5'd0, 1, 2'd1, 2'd1, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h0,  32'h0};  // jal -4
    vecs[3]  = '{32'h008280E7, 5'd5, 5'd0, 1, 2'd0, 2'd1, 0, 0, 0, 0, 32'h8,        32'h10, 32'h0};  // jalr
    vecs[4]  = '{32'hFF832403, 5'd6, 5'd0, 1, 2'd0, 2'd1, 0, 1, 0, 0, 32'hFFFFFFF8, 32'h3,  32'h0};  // lw -8
    vecs[5]  = '{32'h00532623, 5'd6, 5'd5, 0, 2'd0, 2'd1, 0, 0, 1, 0, 32'hC,        32'h3,  32'h10}; // sw 12
    vecs[6]  = '{32'hFE6288E3, 5'd5, 5'd6, 0, 2'd0, 2'd0, 0, 0, 0, 0, 32'hFFFFFFF0, 32'h10, 32'h3};  // beq -16
    vecs[7]  = '{32'h406284B3, 5'd5, 5'd6, 1, 2'd0, 2'd0, 1, 0, 0, 0, 32'h0,        32'h10, 32'h3};  // sub
    vecs[8]  = '{32'h4032D513, 5'd5, 5'd0, 1, 2'd0, 2'd1, 1, 0, 0, 0, 32'h403,      32'h10, 32'h0};  // srai
    vecs[9]  = '{32'h40028593, 5'd5, 5'd0, 1, 2'd0, 2'd1, 0, 0, 0, 0, 32'h400,      32'h10, 32'h0};  // addi, bit30 set
    vecs[10] = '{32'h0000007F, 5'd0, 5'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 32'h0,        32'h0,  32'h0};  // opcode 0x7F

    rst_n = 1'b0; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_write_in = 1'b0; wb_rd_in = '0; wb_value_in = '0;
    ex_load_in = 1'b0; ex_rd_in = '0; instr_in = '0; pc_in = '0;

    repeat (2) @(posedge req);
    #1;
    check("reset out_valid", a_out_valid, 0);
    check("reset in_ready", a_in_ready, 0);
    check("reset pc_out", a_pc, 0);
    check("reset rd_write", a_rd_write, 0);
    check("reset imm", a_imm, 0);
    check("reset stall_count", a_stall, 0);
    rst_n = 1'b1;

    // Load x5=7, x6=3 through the writeback port.
    wb_write_in = 1'b1; wb_rd_in = 5'd5; wb_value_in = 32'd7;
    tick();
    wb_rd_in = 5'd6; wb_value_in = 32'd3;
    tick();
    wb_write_in = 1'b0;

    out_ready = 1'b1;
    present(32'h006283B3, 32'h100);  // add x7,x5,x6
    #1 check("add in_ready", a_in_ready, 1);
    tick();
    check("add out_valid", a_out_valid, 1);
    check("add pc", a_pc, 32'h100);
    check("add rs1_value", a_rs1_val, 7);
    check("add rs2_value", a_rs2_val, 3);
    check("add rd", a_rd, 7);
    check("add rd_write", a_rd_write, 1);
    check("add src2", a_src2, 0);

    // Same-cycle writeback of x5 while decoding a reader of x5.
    present(32'hFFF28293, 32'h104);  // addi x5,x5,-1
    wb_write_in = 1'b1; wb_rd_in = 5'd5; wb_value_in = 32'h10;
    tick();
    wb_write_in = 1'b0;
    check("bypass rs1_value fwd", a_rs1_val, 32'h10);
    check("bypass rs1_value nofwd", b_rs1_val, 7);
    check("bypass imm", a_imm, 32'hFFFFFFFF);
    check("bypass rs2 idx", a_rs2, 0);
    check("bypass rs2_value", a_rs2_val, 0);

    for (int i = 0; i < 11; i++) begin
      present(vecs[i].instr, 32'h1000 + 32'(i * 4));
      tick();
      check($sformatf("v%0d out_valid", i), a_out_valid, 1);
      check($sformatf("v%0d pc", i), a_pc, 32'h1000 + 32'(i * 4));
      check($sformatf("v%0d rs1", i), a_rs1, vecs[i].rs1);
      check($sformatf("v%0d rs2", i), a_rs2, vecs[i].rs2);
      check($sformatf("v%0d rd_write", i), a_rd_write, vecs[i].rd_write);
      check($sformatf("v%0d src1", i), a_src1, vecs[i].src1);
      check($sformatf("v%0d src2", i), a_src2, vecs[i].src2);
      check($sformatf("v%0d sub_sra", i), a_sub, vecs[i].sub);
      check($sformatf("v%0d mem_read", i), a_mread, vecs[i].mread);
      check($sformatf("v%0d mem_write", i), a_mwrite, vecs[i].mwrite);
      check($sformatf("v%0d illegal", i), a_illegal, vecs[i].illegal);
      check($sformatf("v%0d imm", i), a_imm, vecs[i].imm);
      check($sformatf("v%0d rs1_value", i), a_rs1_val, vecs[i].rs1_val);
      check($sformatf("v%0d rs2_value", i), a_rs2_val, vecs[i].rs2_val);
    end

    // rd=20 is legal with 32 registers, illegal with 16.
    present(32'h00628A33, 32'h2000);  // add x20,x5,x6
    tick();
    check("rd20 illegal n32", a_illegal, 0);
    check("rd20 rd_write n32", a_rd_write, 1);
    check("rd20 out_valid n16", b_out_valid, 1);
    check("rd20 illegal n16", b_illegal, 1);
    check("rd20 rd_write n16", b_rd_write, 0);

    // Load-use hazard on x5 for three cycles.
    present(32'h00128613, 32'h300);  // addi x12,x5,1
    ex_load_in = 1'b1; ex_rd_in = 5'd5;
    #1 check("hazard in_ready", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hazard bubble %0d", i), a_out_valid, 0);
    end
    check("hazard stall_count", a_stall, 3);
    ex_load_in = 1'b0;
    #1 check("hazard release in_ready", a_in_ready, 1);
    tick();
    check("hazard issue out_valid", a_out_valid, 1);
    check("hazard issue rd", a_rd, 12);
    check("hazard issue pc", a_pc, 32'h300);
    check("hazard issue rs1_value", a_rs1_val, 32'h10);
    check("hazard stall held", a_stall, 3);

    // Backpressure: bundle held for four cycles.
    present(32'h006283B3, 32'h200);
    tick();
    present(32'h406284B3, 32'h204);
    out_ready = 1'b0;
    #1 check("bp in_ready", a_in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp hold valid %0d", i), a_out_valid, 1);
      check($sformatf("bp hold pc %0d", i), a_pc, 32'h200);
      check($sformatf("bp hold rd %0d", i), a_rd, 7);
      check($sformatf("bp hold in_ready %0d", i), a_in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", a_in_ready, 1);
    tick();
    check("bp next pc", a_pc, 32'h204);
    check("bp next rd", a_rd, 9);
    check("bp next sub_sra", a_sub, 1);

    // Flush with a valid held bundle, a hazard and a writeback to x0 in the same cycle.
    present(32'h00128613, 32'h208);
    out_ready = 1'b0; flush_in = 1'b1;
    ex_load_in = 1'b1; ex_rd_in = 5'd5;
    wb_write_in = 1'b1; wb_rd_in = 5'd0; wb_value_in = 32'hDEAD;
    #1 check("flush in_ready", a_in_ready, 0);
    tick();
    check("flush out_valid", a_out_valid, 0);
    check("flush no stall count", a_stall, 3);
    flush_in = 1'b0; ex_load_in = 1'b0; wb_write_in = 1'b0; in_valid = 1'b0;
    tick();
    check("flush dropped", a_out_valid, 0);
    out_ready = 1'b1;
    present(32'h000006B3, 32'h20C);  // add x13,x0,x0
    tick();
    check("x0 out_valid", a_out_valid, 1);
    check("x0 rs1_value", a_rs1_val, 0);
    check("x0 rs2_value", a_rs2_val, 0);
    check("x0 rd", a_rd, 13);
    in_valid = 1'b0;

    // Asynchronous reset with a valid bundle in flight.
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", a_out_valid, 0);
    check("midreset pc", a_pc, 0);
    check("midreset stall_count", a_stall, 0);
    rst_n = 1'b1;
    tick();
    check("postreset out_valid", a_out_valid, 0);
    present(32'h006283B3, 32'h400);
    tick();
    check("postreset out_valid issue", a_out_valid, 1);
    check("postreset rs1_value", a_rs1_val, 0);
    check("postreset rs2_value", a_rs2_val, 0);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
